mfp_avalon_arbiter_2to1: RTL and testbench

- Shares the single Avalon-MM LPDDR2 port (lpddr2_wrapper, avm_* side) between two masters: m0 is the mfp_system AHB-to-Avalon bridge, m1 is a secondary master such as a DMA or framebuffer reader.
- Arbitrates command ownership and keeps write bursts atomic.
- Tracks outstanding pipelined reads so each readdatavalid beat returns to its issuer.
- Sits between mfp_system and lpddr2_wrapper in the avm_clk domain.

---
 rtl/mfp_avalon_arbiter_pkg.sv | 29 ++
 rtl/mfp_avalon_arb_rd_tracker.sv | 86 ++++++++
 rtl/mfp_avalon_arbiter_2to1.sv | 207 ++++++++++++++++++++
 tb/tb_mfp_avalon_arbiter_2to1.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_avalon_arbiter_pkg.sv
// Shared definitions for the 2:1 Avalon-MM LPDDR2 arbiter: state encodings, owner IDs,
// default read-tracker depth and the round-robin pick helper.
package mfp_avalon_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT  = 2'd1,
      ARB_WBURST = 2'd2
   } arb_state_e;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   localparam int ARB_PEND_DEPTH_DEF = 4;

   // Ties go to the master that did not win last; a sole requester always wins.
   function automatic logic arb_rr_pick(input logic req0, input logic req1, input logic last);
      logic win;
      if (req0 && req1) begin
         win = ~last;
      end else if (req0) begin
         win = ARB_M0;
      end else begin
         win = ARB_M1;
      end
      return win;
   endfunction

endpackage

// File: rtl/mfp_avalon_arb_rd_tracker.sv
// Outstanding-read tracker: FIFO of {issuer, beat count}, head beat counter and a sticky
// error flag for read data that arrives with nothing pending.
module mfp_avalon_arb_rd_tracker
   import mfp_avalon_arbiter_pkg::*;
#(
   parameter int BURST_W    = 3,
   parameter int PEND_DEPTH = ARB_PEND_DEPTH_DEF
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               push_i,
   input  logic               push_owner_i,
   input  logic [BURST_W-1:0] push_cnt_i,
   input  logic               rvalid_i,
   output logic               full_o,
   output logic               empty_o,
   output logic               head_owner_o,
   output logic               arb_err_o
);

   localparam int                 PTR_W    = $clog2(PEND_DEPTH);
   localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(PEND_DEPTH);
   localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

   // A zero burstcount still moves one beat.
   function automatic logic [BURST_W-1:0] eff_cnt(input logic [BURST_W-1:0] c);
      return (c == {BURST_W{1'b0}}) ? ONE_BEAT : c;
   endfunction

   logic [PEND_DEPTH-1:0] own_q;
   logic [BURST_W-1:0]    cnt_q [PEND_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W:0]        count_q;
   logic [BURST_W-1:0]    beat_q;
   logic                  err_q;
   logic                  do_push_s;
   logic                  beat_s;
   logic                  pop_s;

   assign empty_o      = (count_q == {(PTR_W+1){1'b0}});
   assign full_o       = (count_q == FULL_CNT);
   assign head_owner_o = own_q[rd_ptr_q];
   assign arb_err_o    = err_q;
   assign do_push_s    = push_i & ~full_o;
   assign beat_s       = rvalid_i & ~empty_o;
   assign pop_s        = beat_s & (beat_q == (cnt_q[rd_ptr_q] - ONE_BEAT));

   // FIFO storage, pointers, occupancy, head beat counter and sticky error.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         own_q    <= {PEND_DEPTH{1'b0}};
         for (int i = 0; i < PEND_DEPTH; i++) begin
            cnt_q[i] <= ONE_BEAT;
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {(PTR_W+1){1'b0}};
         beat_q   <= {BURST_W{1'b0}};
         err_q    <= 1'b0;
      end else begin
         if (do_push_s) begin
            own_q[wr_ptr_q] <= push_owner_i;
            cnt_q[wr_ptr_q] <= eff_cnt(push_cnt_i);
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            beat_q   <= {BURST_W{1'b0}};
         end else if (beat_s) begin
            beat_q <= beat_q + ONE_BEAT;
         end
         case ({do_push_s, pop_s})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (rvalid_i && empty_o) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mfp_avalon_arbiter_2to1.sv
// 2:1 Avalon-MM arbiter in front of the LPDDR2 port: one-cycle arbitration, atomic write
// bursts, read data routed back to its issuer. MFP_AVALON_ARB_FIXED_PRIO_EN gives m0 fixed priority.
module mfp_avalon_arbiter_2to1
   import mfp_avalon_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BURST_W    = 3,
   parameter int PEND_DEPTH = ARB_PEND_DEPTH_DEF
) (
   input  logic                avm_clk,
   input  logic                avm_rst_n,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic                m0_beginbursttransfer,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [BURST_W-1:0]  m0_burstcount,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic                m0_readdatavalid,
   output logic [DATA_W-1:0]   m0_readdata,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic                m1_beginbursttransfer,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [BURST_W-1:0]  m1_burstcount,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic                m1_readdatavalid,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                avm_read,
   output logic                avm_write,
   output logic                avm_beginbursttransfer,
   output logic                avm_begintransfer,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic [BURST_W-1:0]  avm_burstcount,
   output logic [DATA_W-1:0]   avm_writedata,
   input  logic                avm_waitrequest,
   input  logic                avm_readdatavalid,
   input  logic [DATA_W-1:0]   avm_readdata,
   output logic                arb_err
);

   localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

   arb_state_e         state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic               first_q, first_d;
   logic [BURST_W-1:0] beats_q, beats_d;

   logic               req0_s, req1_s, winner_s;
   logic               o_read_s, o_write_s, o_bbt_s;
   logic [BURST_W-1:0] o_bc_s;
   logic               rd_s, wr_s, bt_s, bbt_s, own_wait_s, push_s;
   logic               rdv_s, rd_full_s, rd_empty_s, rd_head_s;

   assign req0_s = m0_read | m0_write;
   assign req1_s = m1_read | m1_write;

`ifdef MFP_AVALON_ARB_FIXED_PRIO_EN
   assign winner_s = req0_s ? ARB_M0 : ARB_M1;
`else
   assign winner_s = arb_rr_pick(req0_s, req1_s, last_q);
`endif

   assign o_read_s  = owner_q ? m1_read  : m0_read;
   assign o_write_s = owner_q ? m1_write : m0_write;
   assign o_bbt_s   = owner_q ? m1_beginbursttransfer : m0_beginbursttransfer;
   assign o_bc_s    = owner_q ? m1_burstcount : m0_burstcount;

   // Next state, grant bookkeeping and slave-side command qualification.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      first_d    = 1'b0;
      beats_d    = beats_q;
      rd_s       = 1'b0;
      wr_s       = 1'b0;
      bt_s       = 1'b0;
      bbt_s      = 1'b0;
      own_wait_s = 1'b1;
      push_s     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (req0_s || req1_s) begin
               owner_d = winner_s;
               first_d = 1'b1;
               state_d = ARB_GRANT;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            bt_s  = first_q;
            bbt_s = o_bbt_s;
            if (o_read_s) begin
               // Tracker full: hold the read off until a slot frees.
               if (rd_full_s) begin
                  own_wait_s = 1'b1;
               end else begin
                  rd_s       = 1'b1;
                  own_wait_s = avm_waitrequest;
                  if (!avm_waitrequest) begin
                     push_s  = 1'b1;
                     last_d  = owner_q;
                     state_d = ARB_IDLE;
                  end else begin
                     state_d = ARB_GRANT;
                  end
               end
            end else if (o_write_s) begin
               wr_s       = 1'b1;
               own_wait_s = avm_waitrequest;
               if (!avm_waitrequest) begin
                  if (o_bc_s > ONE_BEAT) begin
                     beats_d = o_bc_s - ONE_BEAT;
                     state_d = ARB_WBURST;
                  end else begin
                     last_d  = owner_q;
                     state_d = ARB_IDLE;
                  end
               end else begin
                  state_d = ARB_GRANT;
               end
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_WBURST: begin
            wr_s       = o_write_s;
            own_wait_s = o_write_s ? avm_waitrequest : 1'b1;
            if (o_write_s && !avm_waitrequest) begin
               beats_d = beats_q - ONE_BEAT;
               if (beats_q == ONE_BEAT) begin
                  last_d  = owner_q;
                  state_d = ARB_IDLE;
               end else begin
                  state_d = ARB_WBURST;
               end
            end else begin
               state_d = ARB_WBURST;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge avm_clk) begin
      if (!avm_rst_n) begin
         state_q <= ARB_IDLE;
         owner_q <= ARB_M0;
         last_q  <= ARB_M1;
         first_q <= 1'b0;
         beats_q <= {BURST_W{1'b0}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         first_q <= first_d;
         beats_q <= beats_d;
      end
   end

   mfp_avalon_arb_rd_tracker #(
      .BURST_W    (BURST_W),
      .PEND_DEPTH (PEND_DEPTH)
   ) u_rd_tracker (
      .clk_i        (avm_clk),
      .rst_n_i      (avm_rst_n),
      .push_i       (push_s),
      .push_owner_i (owner_q),
      .push_cnt_i   (o_bc_s),
      .rvalid_i     (rdv_s),
      .full_o       (rd_full_s),
      .empty_o      (rd_empty_s),
      .head_owner_o (rd_head_s),
      .arb_err_o    (arb_err)
   );

   // Reset forces the command side quiet in the same cycle it is asserted.
   assign avm_read               = avm_rst_n & rd_s;
   assign avm_write              = avm_rst_n & wr_s;
   assign avm_begintransfer      = avm_rst_n & bt_s;
   assign avm_beginbursttransfer = avm_rst_n & bbt_s;
   assign avm_address            = owner_q ? m1_address    : m0_address;
   assign avm_byteenable         = owner_q ? m1_byteenable : m0_byteenable;
   assign avm_burstcount         = o_bc_s;
   assign avm_writedata          = owner_q ? m1_writedata  : m0_writedata;

   assign m0_waitrequest = ~avm_rst_n | (owner_q == ARB_M1) | own_wait_s;
   assign m1_waitrequest = ~avm_rst_n | (owner_q == ARB_M0) | own_wait_s;

   assign rdv_s            = avm_readdatavalid & avm_rst_n;
   assign m0_readdatavalid = rdv_s & ~rd_empty_s & (rd_head_s == ARB_M0);
   assign m1_readdatavalid = rdv_s & ~rd_empty_s & (rd_head_s == ARB_M1);
   assign m0_readdata      = avm_readdata;
   assign m1_readdata      = avm_readdata;

endmodule

// File: tb/tb_mfp_avalon_arbiter_2to1.sv
// Directed self-checking bench for mfp_avalon_arbiter_2to1 (default round-robin build;
// the tie-grant expectations follow MFP_AVALON_ARB_FIXED_PRIO_EN when defined).
module tb_mfp_avalon_arbiter_2to1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_read, m0_write, m0_bbt, m1_read, m1_write, m1_bbt;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [2:0]  m0_burstcount, m1_burstcount;
   logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic        avm_read, avm_write, avm_beginbursttransfer, avm_begintransfer;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic [3:0]  avm_byteenable;
   logic [2:0]  avm_burstcount;
   logic        avm_waitrequest, avm_readdatavalid, arb_err;

   int          n_cmp = 0;
   int          n_err = 0;
   logic        exp_own;
   logic [7:0]  own_seq;

   always #5 clk = ~clk;

   mfp_avalon_arbiter_2to1 dut (
      .avm_clk(clk), .avm_rst_n(rst_n),
      .m0_read(m0_read), .m0_write(m0_write), .m0_beginbursttransfer(m0_bbt),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
      .m1_read(m1_read), .m1_write(m1_write), .m1_beginbursttransfer(m1_bbt),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
      .avm_read(avm_read), .avm_write(avm_write),
      .avm_beginbursttransfer(avm_beginbursttransfer), .avm_begintransfer(avm_begintransfer),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata), .arb_err(arb_err)
   );

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m0_read = 1'b0; m0_write = 1'b0; m0_bbt = 1'b0;
      m1_read = 1'b0; m1_write = 1'b0; m1_bbt = 1'b0;
      m0_address = 32'h0; m1_address = 32'h0;
      m0_writedata = 32'h0; m1_writedata = 32'h0;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      m0_burstcount = 3'd1; m1_burstcount = 3'd1;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;

      // Reset state
      cyc(); #1;
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_avm_rd", avm_read, 0);
      chk("rst_avm_wr", avm_write, 0);
      chk("rst_arb_err", arb_err, 0);
      chk("rst_m0_rdv", m0_readdatavalid, 0);
      cyc(); rst_n = 1'b1;

      // Both masters write continuously: grants alternate, m0 first
      cyc();
      m0_write = 1'b1; m0_address = 32'h10; m0_writedata = 32'hA0A0;
      m1_write = 1'b1; m1_address = 32'h20; m1_writedata = 32'hB0B0;
      #1;
      chk("rr_idle0", avm_write, 0);
      for (int g = 0; g < 4; g++) begin
         cyc(); #1;
`ifdef MFP_AVALON_ARB_FIXED_PRIO_EN
         exp_own = 1'b0;
`else
         exp_own = g[0];
`endif
         chk("rr_addr", avm_address, exp_own ? 32'h20 : 32'h10);
         chk("rr_wait", {m1_waitrequest, m0_waitrequest}, exp_own ? 32'd1 : 32'd2);
         chk("rr_wr", avm_write, 1);
         cyc(); #1;
         chk("rr_idle", avm_write, 0);
      end
      m0_write = 1'b0; m1_write = 1'b0;

      // m0 single read, data back three cycles later
      cyc(); m0_read = 1'b1; m0_address = 32'h100; m0_burstcount = 3'd1; #1;
      chk("rd_arb_cycle", avm_read, 0);
      chk("rd_arb_wait", m0_waitrequest, 1);
      cyc(); #1;
      chk("rd_issue", avm_read, 1);
      chk("rd_addr", avm_address, 32'h100);
      chk("rd_bt", avm_begintransfer, 1);
      chk("rd_m0_wait", m0_waitrequest, 0);
      chk("rd_m1_wait", m1_waitrequest, 1);
      cyc(); m0_read = 1'b0; #1;
      chk("rd_done", avm_read, 0);
      cyc(); cyc();
      cyc(); avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF; #1;
      chk("rd_m0_rdv", m0_readdatavalid, 1);
      chk("rd_m0_data", m0_readdata, 32'hDEADBEEF);
      chk("rd_m1_rdv", m1_readdatavalid, 0);
      cyc(); avm_readdatavalid = 1'b0; #1;
      chk("rd_m0_rdv_end", m0_readdatavalid, 0);
      chk("rd_no_err", arb_err, 0);

      // m1 burst of 4 with a stall on beat 2, m0 read held off until the burst ends
      cyc();
      m1_write = 1'b1; m1_burstcount = 3'd4; m1_bbt = 1'b1;
      m1_address = 32'h200; m1_writedata = 32'hA0;
      #1;
      chk("wb_idle", avm_write, 0);
      cyc(); m0_read = 1'b1; m0_address = 32'h300; m0_burstcount = 3'd1; #1;
      chk("wb_b1_wr", avm_write, 1);
      chk("wb_b1_addr", avm_address, 32'h200);
      chk("wb_b1_bc", avm_burstcount, 4);
      chk("wb_b1_bbt", avm_beginbursttransfer, 1);
      chk("wb_b1_m1_wait", m1_waitrequest, 0);
      chk("wb_b1_m0_wait", m0_waitrequest, 1);
      cyc(); m1_bbt = 1'b0; m1_writedata = 32'hA1; avm_waitrequest = 1'b1; #1;
      chk("wb_stall_wr", avm_write, 1);
      chk("wb_stall_wait", m1_waitrequest, 1);
      chk("wb_stall_bbt", avm_beginbursttransfer, 0);
      chk("wb_stall_rd", avm_read, 0);
      cyc(); avm_waitrequest = 1'b0; #1;
      chk("wb_b2_wait", m1_waitrequest, 0);
      chk("wb_b2_data", avm_writedata, 32'hA1);
      chk("wb_b2_m0_wait", m0_waitrequest, 1);
      cyc(); m1_writedata = 32'hA2; #1;
      chk("wb_b3_wr", avm_write, 1);
      chk("wb_b3_rd", avm_read, 0);
      cyc(); m1_writedata = 32'hA3; #1;
      chk("wb_b4_data", avm_writedata, 32'hA3);
      chk("wb_b4_rd", avm_read, 0);
      cyc(); m1_write = 1'b0; #1;
      chk("wb_end_wr", avm_write, 0);
      chk("wb_end_m0_wait", m0_waitrequest, 1);
      cyc(); #1;
      chk("wb_m0_rd", avm_read, 1);
      chk("wb_m0_addr", avm_address, 32'h300);
      chk("wb_m0_wait", m0_waitrequest, 0);
      cyc(); m0_read = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'h11111111; #1;
      chk("wb_m0_rdv", m0_readdatavalid, 1);
      chk("wb_m1_rdv", m1_readdatavalid, 0);
      cyc(); avm_readdatavalid = 1'b0;

      // Five 2-beat reads: four fill the tracker, the fifth waits for a slot
      m0_read = 1'b1; m1_read = 1'b1;
      m0_burstcount = 3'd2; m1_burstcount = 3'd2;
      m0_address = 32'h400; m1_address = 32'h500;
      #1;
      chk("pr_idle", avm_read, 0);
      for (int r = 0; r < 4; r++) begin
         cyc(); #1;
         chk("pr_issue", avm_read, 1);
         chk("pr_addr", avm_address, r[0] ? 32'h400 : 32'h500);
         chk("pr_bc", avm_burstcount, 2);
         cyc();
         if (r == 3) m0_read = 1'b0;
         #1;
         chk("pr_gap", avm_read, 0);
      end
      cyc(); #1;
      chk("pr_full_rd", avm_read, 0);
      chk("pr_full_wait", m1_waitrequest, 1);
      chk("pr_full_addr", avm_address, 32'h500);
      cyc(); avm_readdatavalid = 1'b1; avm_readdata = 32'hB0; #1;
      chk("pr_b0_m1", m1_readdatavalid, 1);
      chk("pr_b0_m0", m0_readdatavalid, 0);
      chk("pr_b0_wait", m1_waitrequest, 1);
      cyc(); avm_readdata = 32'hB1; #1;
      chk("pr_b1_m1", m1_readdatavalid, 1);
      chk("pr_b1_rd", avm_read, 0);
      chk("pr_b1_wait", m1_waitrequest, 1);
      cyc(); avm_readdatavalid = 1'b0; #1;
      chk("pr_fifth_rd", avm_read, 1);
      chk("pr_fifth_wait", m1_waitrequest, 0);
      chk("pr_fifth_bt", avm_begintransfer, 0);
      own_seq = 8'b11001100;
      for (int k = 0; k < 8; k++) begin
         cyc();
         m1_read = 1'b0;
         avm_readdatavalid = 1'b1; avm_readdata = 32'hC0000000 + 32'(k);
         #1;
         chk("pr_rdv_m0", m0_readdatavalid, {31'd0, ~own_seq[k]});
         chk("pr_rdv_m1", m1_readdatavalid, {31'd0, own_seq[k]});
         chk("pr_data", m0_readdata, 32'hC0000000 + 32'(k));
      end
      cyc(); avm_readdatavalid = 1'b0; #1;
      chk("pr_end_m0", m0_readdatavalid, 0);
      chk("pr_end_m1", m1_readdatavalid, 0);
      chk("pr_end_err", arb_err, 0);

      // Read data with nothing pending
      cyc(); avm_readdatavalid = 1'b1; avm_readdata = 32'h55; #1;
      chk("err_m0_rdv", m0_readdatavalid, 0);
      chk("err_m1_rdv", m1_readdatavalid, 0);
      chk("err_not_yet", arb_err, 0);
      cyc(); avm_readdatavalid = 1'b0; #1;
      chk("err_set", arb_err, 1);
      cyc(); #1;
      chk("err_sticky", arb_err, 1);

      // Reset during a write burst, then a fresh m1 write
      cyc();
      m1_write = 1'b1; m1_burstcount = 3'd3; m1_address = 32'h600; m1_writedata = 32'h61;
      #1;
      chk("rb_idle", avm_write, 0);
      cyc(); #1;
      chk("rb_b1_wr", avm_write, 1);
      chk("rb_b1_addr", avm_address, 32'h600);
      cyc(); rst_n = 1'b0; m1_writedata = 32'h62; #1;
      chk("rb_rst_wr", avm_write, 0);
      chk("rb_rst_m0_wait", m0_waitrequest, 1);
      chk("rb_rst_m1_wait", m1_waitrequest, 1);
      cyc(); rst_n = 1'b1; m1_burstcount = 3'd1; m1_address = 32'h700; #1;
      chk("rb_post_wr", avm_write, 0);
      chk("rb_post_m1_wait", m1_waitrequest, 1);
      chk("rb_post_m0_wait", m0_waitrequest, 1);
      chk("rb_post_err", arb_err, 0);
      cyc(); #1;
      chk("rb_new_wr", avm_write, 1);
      chk("rb_new_addr", avm_address, 32'h700);
      chk("rb_new_bt", avm_begintransfer, 1);
      chk("rb_new_bc", avm_burstcount, 1);
      chk("rb_new_wait", m1_waitrequest, 0);
      cyc(); m1_write = 1'b0; #1;
      chk("rb_new_done", avm_write, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
